// File: rtl/button_conditioner_pkg.sv
// Shared types and helpers for the push-button conditioner.
package button_conditioner_pkg;

    // Per-channel debounce / auto-repeat states.
    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REPEAT,
        RELEASE_WAIT
    } btn_state_t;

    // Counter width large enough to hold (max timing constant - 1).
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One button channel: 2-FF synchroniser, debounce FSM and auto-repeat timer.
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             s0;
    logic             s1;
    btn_state_t       state_q;
    btn_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_d;
    logic             press_d;
    logic             release_d;

    // Two-stage synchroniser for the asynchronous raw input.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            s0 <= raw;
            s1 <= s0;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            level         <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
        end
    end

    // Next-state, counter and pulse decode acting on the synchronised input.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s1) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s1) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!s1) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (REPEAT_EN != 0 && cnt_q == DLY_LAST) begin
                    state_d = REPEAT;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else if (cnt_q != '1) begin
                    // Saturating so a long hold without repeat never wraps.
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (!s1) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == PER_LAST) begin
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (s1) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: NUM_BTN independent debounced channels with auto-repeat.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic               clk,
    input  logic               btnC,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

    // One self-contained channel per button.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk           (clk),
            .rst           (btnC),
            .raw           (btn_raw[i]),
            .level         (btn_level[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: one repeating and one non-repeating instance share stimulus.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       btnC;
    logic [1:0] btn_raw;
    logic [1:0] lvl_r, prs_r, rel_r;
    logic [1:0] lvl_n, prs_n, rel_n;
    int         n_checks = 0;
    int         n_bad    = 0;
    int         n_press;

    always #5 clk = ~clk;

    button_conditioner #(
        .NUM_BTN(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk), .btnC(btnC), .btn_raw(btn_raw),
        .btn_level(lvl_r), .btn_press(prs_r), .btn_release(rel_r)
    );

    button_conditioner #(
        .NUM_BTN(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut_norpt (
        .clk(clk), .btnC(btnC), .btn_raw(btn_raw),
        .btn_level(lvl_n), .btn_press(prs_n), .btn_release(rel_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        btn_raw = '0;
        repeat (n) tick();
    endtask

    initial begin
        btnC    = 1'b1;
        btn_raw = '0;
        tick();
        tick();
        btnC = 1'b0;

        // Reset state
        check("rst lvl_r", 32'(lvl_r), 32'd0);
        check("rst prs_r", 32'(prs_r), 32'd0);
        check("rst rel_r", 32'(rel_r), 32'd0);
        check("rst lvl_n", 32'(lvl_n), 32'd0);
        check("rst prs_n", 32'(prs_n), 32'd0);
        check("rst rel_n", 32'(rel_n), 32'd0);
        idle(3);

        // Clean press, no repeat: press after edge 6, release after edge 26
        for (int e = 0; e <= 27; e++) begin
            btn_raw[0] = (e <= 19);
            tick();
            check($sformatf("t1 press e%0d", e), 32'(prs_n), 32'(e == 6));
            check($sformatf("t1 level e%0d", e), 32'(lvl_n[0]), 32'(e >= 6 && e <= 25));
            check($sformatf("t1 release e%0d", e), 32'(rel_n), 32'(e == 26));
        end
        idle(4);

        // Press bounce: three high samples are rejected
        for (int e = 0; e <= 12; e++) begin
            btn_raw[0] = (e <= 2);
            tick();
            check($sformatf("t2 press_r e%0d", e), 32'(prs_r), 32'd0);
            check($sformatf("t2 level_r e%0d", e), 32'(lvl_r), 32'd0);
            check($sformatf("t2 press_n e%0d", e), 32'(prs_n), 32'd0);
        end
        idle(3);

        // Auto-repeat
        n_press = 0;
        for (int e = 0; e <= 40; e++) begin
            btn_raw[0] = (e <= 29);
            tick();
            if (prs_r[0]) n_press++;
            check($sformatf("t3 press e%0d", e), 32'(prs_r),
                  32'(e == 6 || e == 16 || e == 19 || e == 22 || e == 25 || e == 28 || e == 31));
            check($sformatf("t3 level e%0d", e), 32'(lvl_r[0]), 32'(e >= 6 && e <= 35));
            check($sformatf("t3 release e%0d", e), 32'(rel_r), 32'(e == 36));
        end
        check("t3 press count", 32'(n_press), 32'd7);
        idle(4);

        // Release bounce restarts the repeat delay: first repeat moves to edge 22
        for (int e = 0; e <= 26; e++) begin
            btn_raw[0] = !(e == 8 || e == 9);
            tick();
            check($sformatf("t4 press e%0d", e), 32'(prs_r), 32'(e == 6 || e == 22 || e == 25));
            check($sformatf("t4 level e%0d", e), 32'(lvl_r[0]), 32'(e >= 6));
            check($sformatf("t4 release e%0d", e), 32'(rel_r), 32'd0);
        end

        // Reset mid-repeat with raw still high
        btnC = 1'b1;
        tick();
        btnC = 1'b0;
        check("t5 rst lvl_r", 32'(lvl_r), 32'd0);
        check("t5 rst prs_r", 32'(prs_r), 32'd0);
        check("t5 rst rel_r", 32'(rel_r), 32'd0);
        check("t5 rst lvl_n", 32'(lvl_n), 32'd0);
        check("t5 rst rel_n", 32'(rel_n), 32'd0);
        for (int e = 0; e <= 10; e++) begin
            btn_raw[0] = 1'b1;
            tick();
            check($sformatf("t5 press_r e%0d", e), 32'(prs_r), 32'(e == 6));
            check($sformatf("t5 release_r e%0d", e), 32'(rel_r), 32'd0);
            check($sformatf("t5 level_r e%0d", e), 32'(lvl_r[0]), 32'(e >= 6));
            check($sformatf("t5 press_n e%0d", e), 32'(prs_n), 32'(e == 6));
            check($sformatf("t5 release_n e%0d", e), 32'(rel_n), 32'd0);
        end
        idle(12);

        // Independence: ch0 clean, ch1 bounces
        for (int e = 0; e <= 12; e++) begin
            btn_raw[0] = (e <= 9);
            btn_raw[1] = (e <= 1);
            tick();
            check($sformatf("t6 press0 e%0d", e), 32'(prs_r[0]), 32'(e == 6));
            check($sformatf("t6 level0 e%0d", e), 32'(lvl_r[0]), 32'(e >= 6));
            check($sformatf("t6 press1 e%0d", e), 32'(prs_r[1]), 32'd0);
            check($sformatf("t6 level1 e%0d", e), 32'(lvl_r[1]), 32'd0);
            check($sformatf("t6 release e%0d", e), 32'(rel_r), 32'd0);
        end
        idle(10);
        check("t6 final level", 32'(lvl_r), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
